// File: rtl/hs_ram_arbiter_pkg.sv
// Shared types and helpers for the hiscore RAM arbiter.
// State encoding, counter widths and the default hiscore write window.
package hs_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAUSE_REQ,
    GUARD,
    GRANT,
    RELEASE
  } state_t;

  localparam logic [15:0] WIN_LO_DEF = 16'h6000;
  localparam logic [15:0] WIN_HI_DEF = 16'h6FFF;

  // A counter that runs 0..n-1 needs $clog2(n) bits, never fewer than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int guard_w(input int guard_cyc);
    return cnt_w(guard_cyc);
  endfunction

  function automatic int tmo_w(input int timeout_cyc);
    return cnt_w(timeout_cyc);
  endfunction

endpackage

// File: rtl/hs_ram_arbiter_if.sv
// Bus bundle joining the CPU RAM port, the hiscore engine and the RAM.
// The arbiter takes the slave view; the surrounding logic takes the master view.
interface hs_ram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we;
  logic          cpu_paused;
  logic          pause_req;
  logic          hs_req;
  logic          hs_grant;
  logic [AW-1:0] hs_addr;
  logic [DW-1:0] hs_wdata;
  logic          hs_we;
  logic          hs_rd;
  logic [DW-1:0] hs_rdata;
  logic          hs_rvalid;
  logic          hs_err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_paused,
    input  hs_req, hs_addr, hs_wdata, hs_we, hs_rd,
    input  ram_q,
    output pause_req, hs_grant, hs_rdata, hs_rvalid, hs_err,
    output ram_addr, ram_wdata, ram_we
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_paused,
    output hs_req, hs_addr, hs_wdata, hs_we, hs_rd,
    output ram_q,
    input  pause_req, hs_grant, hs_rdata, hs_rvalid, hs_err,
    input  ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/hs_ram_arbiter_rd_pipe.sv
// Two-stage hiscore read pipeline: issue -> RAM latency -> capture.
// Runs independently of the grant so a read in the last granted cycle completes.
module hs_arb_rd_pipe #(
  parameter int DW = 8
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          i_rd,
  input  logic [DW-1:0] i_q,
  output logic [DW-1:0] o_rdata,
  output logic          o_rvalid
);
  logic          r_rd1;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;

  // Track the outstanding read and capture RAM data one cycle after issue.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_rd1    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rd1    <= i_rd;
      r_rvalid <= r_rd1;
      if (r_rd1)
        r_rdata <= i_q;
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
endmodule

// File: rtl/hs_ram_arbiter.sv
// Hands the CPU work-RAM port to the hiscore engine while the CPU is paused.
// Define HS_ARB_WINDOW_EN to restrict hiscore writes to [WIN_LO, WIN_HI].
module hs_ram_arbiter
  import hs_arb_pkg::*;
#(
  parameter int            AW          = 16,
  parameter int            DW          = 8,
  parameter int            GUARD_CYC   = 4,
  parameter int            TIMEOUT_CYC = 65535,
  parameter logic [AW-1:0] WIN_LO      = AW'(WIN_LO_DEF),
  parameter logic [AW-1:0] WIN_HI      = AW'(WIN_HI_DEF)
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  hs_ram_arbiter_if.slave  bus
);
  localparam int            GW     = guard_w(GUARD_CYC);
  localparam int            TW     = tmo_w(TIMEOUT_CYC);
  localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYC - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        r_state;
  logic          r_pause_req;
  logic          r_hs_grant;
  logic          r_hs_err;
  logic          r_rearm;
  logic [GW-1:0] r_gcnt;
  logic [TW-1:0] r_tcnt;

  logic          w_in_win;
  logic          w_blk;
  logic          w_rd_issue;

`ifdef HS_ARB_WINDOW_EN
  assign w_in_win = (bus.hs_addr >= WIN_LO) &&
                    (bus.hs_addr <= WIN_HI);
`else
  logic w_unused_win;
  assign w_unused_win = ^{WIN_LO, WIN_HI};
  assign w_in_win     = 1'b1;
`endif

  assign w_blk      = r_hs_grant & bus.hs_we & ~w_in_win;
  assign w_rd_issue = r_hs_grant & bus.hs_rd & ~bus.hs_we;

  // Hand-over sequencer: pause, settle, grant, release, settle.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pause_req <= 1'b0;
      r_hs_grant  <= 1'b0;
      r_hs_err    <= 1'b0;
      r_rearm     <= 1'b1;
      r_gcnt      <= '0;
      r_tcnt      <= '0;
    end else begin
      r_hs_err <= w_blk;
      if (!bus.hs_req)
        r_rearm <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (bus.hs_req && r_rearm) begin
            r_state     <= PAUSE_REQ;
            r_pause_req <= 1'b1;
            r_tcnt      <= '0;
          end
        end
        PAUSE_REQ: begin
          if (!bus.hs_req) begin
            r_state     <= IDLE;
            r_pause_req <= 1'b0;
          end else if (bus.cpu_paused) begin
            r_state <= GUARD;
            r_gcnt  <= '0;
          end else if (r_tcnt == T_LAST) begin
            r_state     <= IDLE;
            r_pause_req <= 1'b0;
            r_hs_err    <= 1'b1;
            r_rearm     <= 1'b0;
          end else if (r_tcnt != '1) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        GUARD: begin
          if (!bus.hs_req) begin
            r_state     <= IDLE;
            r_pause_req <= 1'b0;
          end else if (!bus.cpu_paused) begin
            r_state <= PAUSE_REQ;
          end else if (r_gcnt == G_LAST) begin
            r_state    <= GRANT;
            r_hs_grant <= 1'b1;
          end else if (r_gcnt != '1) begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        GRANT: begin
          if (!bus.hs_req || !bus.cpu_paused) begin
            r_state    <= RELEASE;
            r_hs_grant <= 1'b0;
            r_gcnt     <= '0;
            if (bus.hs_req)
              r_hs_err <= 1'b1;
          end
        end
        RELEASE: begin
          if (r_gcnt == G_LAST) begin
            r_state     <= IDLE;
            r_pause_req <= 1'b0;
          end else if (r_gcnt != '1) begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_pause_req <= 1'b0;
          r_hs_grant  <= 1'b0;
        end
      endcase
    end
  end

  hs_arb_rd_pipe #(.DW(DW)) u_rd_pipe (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .i_rd     (w_rd_issue),
    .i_q      (bus.ram_q),
    .o_rdata  (bus.hs_rdata),
    .o_rvalid (bus.hs_rvalid)
  );

  assign bus.ram_addr  = r_hs_grant ? bus.hs_addr  : bus.cpu_addr;
  assign bus.ram_wdata = r_hs_grant ? bus.hs_wdata : bus.cpu_wdata;
  assign bus.ram_we    = r_hs_grant ? (bus.hs_we & w_in_win)
                                    : bus.cpu_we;

  assign bus.pause_req = r_pause_req;
  assign bus.hs_grant  = r_hs_grant;
  assign bus.hs_err    = r_hs_err;
endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter with a behavioural synchronous RAM.
// Checks HS_ARB_WINDOW_EN behaviour for whichever way the macro is set.
module tb_hs_ram_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] r_q;

  hs_ram_arbiter_if #(.AW(16), .DW(8)) bus ();

  hs_ram_arbiter #(
    .GUARD_CYC   (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we)
      mem[bus.ram_addr] <= bus.ram_wdata;
    r_q <= mem[bus.ram_addr];
  end
  assign bus.ram_q = r_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acquire();
    bit ok = 1'b0;
    bus.hs_req     = 1'b1;
    bus.cpu_paused = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (bus.hs_grant === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL acquire: grant=%b want 1 within 20 cycles", bus.hs_grant);
    end
  endtask

  task automatic release_port();
    bit ok = 1'b0;
    bus.hs_req = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (bus.pause_req === 1'b0) ok = 1'b1;
    end
    bus.cpu_paused = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL release: pause_req=%b want 0 within 20 cycles", bus.pause_req);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    bus.cpu_addr = 16'h1234;
    #1;
    checks++;
    if ({bus.pause_req, bus.hs_grant, bus.hs_rvalid, bus.hs_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.pause_req, bus.hs_grant, bus.hs_rvalid, bus.hs_err});
    end
    checks++;
    if (bus.hs_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 00", bus.hs_rdata);
    end
    checks++;
    if (bus.ram_addr !== 16'h1234) begin
      errors++;
      $display("FAIL reset_mux: ram_addr=%h want 1234", bus.ram_addr);
    end
  endtask

  task automatic test_basic_grant();
    bus.hs_req = 1'b1;
    tick();
    checks++;
    if (bus.pause_req !== 1'b1) begin
      errors++;
      $display("FAIL pause_req_rise: got %b want 1", bus.pause_req);
    end
    tick();
    tick();
    bus.cpu_paused = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (bus.hs_grant !== (k == 5)) begin
        errors++;
        $display("FAIL grant_timing k=%0d: got %b want %b", k, bus.hs_grant, k == 5);
      end
    end
    bus.hs_req = 1'b0;
    tick();
    checks++;
    if ({bus.hs_grant, bus.pause_req} !== 2'b01) begin
      errors++;
      $display("FAIL grant_fall: grant,pause=%b want 01", {bus.hs_grant, bus.pause_req});
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (bus.pause_req !== (k < 4)) begin
        errors++;
        $display("FAIL release_guard k=%0d: pause=%b want %b", k, bus.pause_req, k < 4);
      end
    end
    bus.cpu_paused = 1'b0;
  endtask

  task automatic test_read_pipeline();
    mem[16'h6010] = 8'hA5;
    mem[16'h6011] = 8'h5A;
    acquire();
    bus.hs_addr = 16'h6010;
    bus.hs_rd   = 1'b1;
    tick();
    bus.hs_addr = 16'h6011;
    checks++;
    if (bus.hs_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_t1: rvalid=%b want 0", bus.hs_rvalid);
    end
    tick();
    bus.hs_rd = 1'b0;
    checks++;
    if ({bus.hs_rvalid, bus.hs_rdata} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL rd_t2: rvalid,rdata=%b,%h want 1,a5", bus.hs_rvalid, bus.hs_rdata);
    end
    tick();
    checks++;
    if ({bus.hs_rvalid, bus.hs_rdata} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL rd_b2b: rvalid,rdata=%b,%h want 1,5a", bus.hs_rvalid, bus.hs_rdata);
    end
    tick();
    checks++;
    if (bus.hs_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_end: rvalid=%b want 0", bus.hs_rvalid);
    end
    bus.hs_addr = 16'h6010;
    bus.hs_rd   = 1'b1;
    bus.hs_req  = 1'b0;
    tick();
    bus.hs_rd = 1'b0;
    checks++;
    if ({bus.hs_grant, bus.hs_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rd_last_t1: grant,rvalid=%b want 00", {bus.hs_grant, bus.hs_rvalid});
    end
    tick();
    checks++;
    if ({bus.hs_rvalid, bus.hs_rdata} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL rd_last_t2: rvalid,rdata=%b,%h want 1,a5", bus.hs_rvalid, bus.hs_rdata);
    end
    release_port();
  endtask

  task automatic test_contention();
    mem[16'h6020] = 8'hEE;
    mem[16'h6021] = 8'h00;
    mem[16'h6012] = 8'h00;
    acquire();
    bus.cpu_addr  = 16'h6020;
    bus.cpu_wdata = 8'h11;
    bus.cpu_we    = 1'b1;
    bus.hs_addr   = 16'h6021;
    bus.hs_wdata  = 8'h22;
    bus.hs_we     = 1'b1;
    #1;
    checks++;
    if ({bus.ram_we, bus.ram_addr} !== {1'b1, 16'h6021}) begin
      errors++;
      $display("FAIL cont_mux: we,addr=%b,%h want 1,6021", bus.ram_we, bus.ram_addr);
    end
    tick();
    bus.cpu_we  = 1'b0;
    bus.hs_addr = 16'h6012;
    bus.hs_wdata = 8'h33;
    bus.hs_rd   = 1'b1;
    checks++;
    if ({mem[16'h6021], mem[16'h6020]} !== 16'h22EE) begin
      errors++;
      $display("FAIL cont_ram: [6021],[6020]=%h,%h want 22,ee",
               mem[16'h6021], mem[16'h6020]);
    end
    tick();
    bus.hs_we = 1'b0;
    bus.hs_rd = 1'b0;
    tick();
    checks++;
    if (bus.hs_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL we_rd_rvalid: got %b want 0", bus.hs_rvalid);
    end
    checks++;
    if (mem[16'h6012] !== 8'h33) begin
      errors++;
      $display("FAIL we_rd_write: [6012]=%h want 33", mem[16'h6012]);
    end
    release_port();
  endtask

  task automatic test_timeout();
    int n = 0;
    int hi = 0;
    bit done = 1'b0;
    bus.cpu_paused = 1'b0;
    bus.hs_req     = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (bus.pause_req === 1'b1) n++;
      else done = 1'b1;
    end
    checks++;
    if (!done || n != 16) begin
      errors++;
      $display("FAIL tmo_len: pause cycles=%0d want 16", n);
    end
    checks++;
    if (bus.hs_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_err: hs_err=%b want 1", bus.hs_err);
    end
    tick();
    checks++;
    if (bus.hs_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err_pulse: hs_err=%b want 0", bus.hs_err);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.pause_req !== 1'b0) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL tmo_no_retry: pause cycles=%0d want 0", hi);
    end
    bus.hs_req = 1'b0;
    tick();
    bus.hs_req = 1'b1;
    tick();
    checks++;
    if (bus.pause_req !== 1'b1) begin
      errors++;
      $display("FAIL tmo_rearm: pause=%b want 1", bus.pause_req);
    end
    bus.hs_req = 1'b0;
    tick();
    checks++;
    if (bus.pause_req !== 1'b0) begin
      errors++;
      $display("FAIL tmo_abandon: pause=%b want 0", bus.pause_req);
    end
  endtask

  task automatic test_violation();
    acquire();
    bus.cpu_paused = 1'b0;
    tick();
    bus.hs_req = 1'b0;
    checks++;
    if ({bus.hs_grant, bus.hs_err, bus.pause_req} !== 3'b011) begin
      errors++;
      $display("FAIL viol: grant,err,pause=%b want 011",
               {bus.hs_grant, bus.hs_err, bus.pause_req});
    end
    release_port();
  endtask

  task automatic test_reset_mid_grant();
    acquire();
    bus.hs_addr = 16'h6010;
    bus.hs_rd   = 1'b1;
    tick();
    reset_n        = 1'b0;
    bus.hs_rd      = 1'b0;
    bus.hs_req     = 1'b0;
    bus.cpu_paused = 1'b0;
    bus.cpu_addr   = 16'h1357;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({bus.hs_grant, bus.pause_req, bus.hs_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid: grant,pause,rvalid=%b want 000",
               {bus.hs_grant, bus.pause_req, bus.hs_rvalid});
    end
    checks++;
    if (bus.ram_addr !== 16'h1357) begin
      errors++;
      $display("FAIL rst_mid_mux: ram_addr=%h want 1357", bus.ram_addr);
    end
    tick();
    checks++;
    if (bus.hs_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_rvalid: got %b want 0", bus.hs_rvalid);
    end
  endtask

  task automatic test_window();
    bit en;
`ifdef HS_ARB_WINDOW_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    mem[16'h7000] = 8'h00;
    mem[16'h6FFF] = 8'h00;
    acquire();
    bus.hs_addr  = 16'h7000;
    bus.hs_wdata = 8'h44;
    bus.hs_we    = 1'b1;
    #1;
    checks++;
    if (bus.ram_we !== !en) begin
      errors++;
      $display("FAIL win_out_we: ram_we=%b want %b", bus.ram_we, !en);
    end
    tick();
    bus.hs_we = 1'b0;
    checks++;
    if (bus.hs_err !== en) begin
      errors++;
      $display("FAIL win_out_err: hs_err=%b want %b", bus.hs_err, en);
    end
    checks++;
    if (mem[16'h7000] !== (en ? 8'h00 : 8'h44)) begin
      errors++;
      $display("FAIL win_out_ram: [7000]=%h want %h", mem[16'h7000], en ? 8'h00 : 8'h44);
    end
    bus.hs_addr  = 16'h6FFF;
    bus.hs_wdata = 8'h55;
    bus.hs_we    = 1'b1;
    #1;
    checks++;
    if (bus.ram_we !== 1'b1) begin
      errors++;
      $display("FAIL win_in_we: ram_we=%b want 1", bus.ram_we);
    end
    tick();
    bus.hs_we = 1'b0;
    checks++;
    if ({bus.hs_err, mem[16'h6FFF]} !== {1'b0, 8'h55}) begin
      errors++;
      $display("FAIL win_in: err,[6fff]=%b,%h want 0,55", bus.hs_err, mem[16'h6FFF]);
    end
    release_port();
  endtask

  initial begin
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.cpu_we     = 1'b0;
    bus.cpu_paused = 1'b0;
    bus.hs_req     = 1'b0;
    bus.hs_addr    = '0;
    bus.hs_wdata   = '0;
    bus.hs_we      = 1'b0;
    bus.hs_rd      = 1'b0;
    test_reset();
    test_basic_grant();
    test_read_pipeline();
    test_contention();
    test_timeout();
    test_violation();
    test_reset_mid_grant();
    test_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
